// File: rtl/pipe_ctrl_defs.sv
// rtl/pipe_ctrl_defs.sv - shared state encodings and sizing for the pipeline controller
// Purpose: state enum, counter widths and default data-memory stall limit,
//          shared by pipe_ctrl, its hazard unit and the testbench.
// Ports:   none (package).
package pipe_ctrl_defs;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_W          = 8;
  localparam int STALL_W         = 16;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - single-bit flip-flop primitive with asynchronous active-low reset
// Purpose: storage cell for controller state.
// Ports:   clk - clock; rst - async active-low reset (loads RST_VAL);
//          d - next value; q - registered value.
module dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RST_VAL;
    else      q <= d;
  end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - combinational hazard resolution and next-state logic
// Purpose: turns pipeline events into register enables/flushes and the next
//          controller state; also steers the wait counter.
// Ports:   rst - active-low reset (forces no-event outputs while low);
//          state - current state; id_load_use, imem_stall, dmem_req,
//          dmem_done, br_taken, halt_wb - pipeline events;
//          wait_cnt - consecutive busy cycles so far;
//          *_en / *_flush - pipeline register controls;
//          pc_sel_branch, dmem_cancel - branch redirect controls;
//          wait_inc, wait_clr - wait counter controls; state_nxt - next state.
module pipe_ctrl_hazard
  import pipe_ctrl_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              rst,
  input  state_t            state,
  input  logic              id_load_use,
  input  logic              imem_stall,
  input  logic              dmem_req,
  input  logic              dmem_done,
  input  logic              br_taken,
  input  logic              halt_wb,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_flush,
  output logic              pc_sel_branch,
  output logic              dmem_cancel,
  output logic              wait_inc,
  output logic              wait_clr,
  output state_t            state_nxt
);

  // wait_cnt value seen during the last tolerated busy cycle
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

  logic busy;
  assign busy = dmem_req && !dmem_done;

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    dmem_cancel   = 1'b0;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;
    state_nxt     = state;

    if (!rst) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN, ST_DWAIT: begin
          // any cycle that is not an accepted busy cycle ends the wait run
          wait_clr  = 1'b1;
          state_nxt = ST_RUN;
          if (halt_wb) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            state_nxt = ST_HALTED;
          end else if (br_taken) begin
            // redirect wins over a pending access: that access is wrong-path
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            pc_sel_branch = 1'b1;
            dmem_cancel   = 1'b1;
          end else if (busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            wait_clr    = 1'b0;
            wait_inc    = 1'b1;
            state_nxt   = (wait_cnt == LIMIT) ? ST_ERR : ST_DWAIT;
          end else if (id_load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (imem_stall) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        default: begin
          // HALTED and ERR are terminal until reset
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear
// Purpose: counts enabled cycles, sticks at all-ones instead of wrapping.
// Ports:   clk - clock; rst - async active-low reset to zero;
//          en - count this cycle; clr - return to zero (wins over en);
//          q - current count.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       q <= '0;
    else if (clr)                   q <= '0;
    else if (en && (q != {W{1'b1}})) q <= q + W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush/halt controller
// Purpose: holds controller state and counters, wires the hazard unit to the
//          pipeline register controls.
// Ports:   clk - clock; rst - async active-low reset;
//          id_load_use, imem_stall, dmem_req, dmem_done, br_taken, halt_wb - events;
//          pc_en, ifid_en, idex_en, exmem_en, memwb_en - register load enables;
//          ifid_flush, idex_flush, exmem_flush, memwb_flush - bubble inserts;
//          pc_sel_branch - PC takes branch target; dmem_cancel - abort access;
//          halted, err - terminal state flags; state - current state;
//          stall_cnt - saturating count of cycles with the PC held.
module pipe_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_load_use,
  input  logic               imem_stall,
  input  logic               dmem_req,
  input  logic               dmem_done,
  input  logic               br_taken,
  input  logic               halt_wb,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               memwb_flush,
  output logic               pc_sel_branch,
  output logic               dmem_cancel,
  output logic               halted,
  output logic               err,
  output logic [1:0]         state,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [1:0]        state_bits;
  logic [1:0]        nxt_bits;
  state_t            state_q;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              wait_clr;
  logic              active;
  logic              stall_inc;

  assign state_q  = state_t'(state_bits);
  assign nxt_bits = state_nxt;

  for (genvar i = 0; i < 2; i++) begin : g_state
    dff #(.RST_VAL(1'b0)) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (nxt_bits[i]),
      .q   (state_bits[i])
    );
  end

  pipe_ctrl_hazard #(.TIMEOUT(TIMEOUT)) u_hazard (
    .rst           (rst),
    .state         (state_q),
    .id_load_use   (id_load_use),
    .imem_stall    (imem_stall),
    .dmem_req      (dmem_req),
    .dmem_done     (dmem_done),
    .br_taken      (br_taken),
    .halt_wb       (halt_wb),
    .wait_cnt      (wait_cnt),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .memwb_flush   (memwb_flush),
    .pc_sel_branch (pc_sel_branch),
    .dmem_cancel   (dmem_cancel),
    .wait_inc      (wait_inc),
    .wait_clr      (wait_clr),
    .state_nxt     (state_nxt)
  );

  sat_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (wait_inc),
    .clr (wait_clr),
    .q   (wait_cnt)
  );

  // only RUN/DWAIT cycles count; terminal states also hold pc_en low
  assign active    = (state_q == ST_RUN) || (state_q == ST_DWAIT);
  assign stall_inc = active && !pc_en;

  sat_cnt #(.W(STALL_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_inc),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  assign state  = state_bits;
  assign halted = (state_q == ST_HALTED);
  assign err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_load_use = 1'b0, imem_stall = 1'b0, dmem_req = 1'b0;
  logic dmem_done = 1'b0, br_taken = 1'b0, halt_wb = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic pc_sel_branch, dmem_cancel, halted, err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_load_use(id_load_use), .imem_stall(imem_stall),
    .dmem_req(dmem_req), .dmem_done(dmem_done),
    .br_taken(br_taken), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .pc_sel_branch(pc_sel_branch), .dmem_cancel(dmem_cancel),
    .halted(halted), .err(err), .state(state), .stall_cnt(stall_cnt)
  );

  // inputs {halt_wb, br_taken, dmem_req, dmem_done, id_load_use, imem_stall}
  localparam logic [5:0] I_IDLE = 6'b000000;
  localparam logic [5:0] I_BUSY = 6'b001000;
  localparam logic [5:0] I_DONE = 6'b001100;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_HALT = 6'b100000;
  localparam logic [5:0] I_LU   = 6'b000010;
  localparam logic [5:0] I_IM   = 6'b000001;
  // enables {pc, ifid, idex, exmem, memwb}
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_BUSY = 5'b00001;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [4:0] EN_IM   = 5'b01111;
  // flushes {ifid, idex, exmem, memwb}
  localparam logic [3:0] FL_NONE = 4'b0000;
  localparam logic [3:0] FL_BUSY = 4'b0001;
  localparam logic [3:0] FL_BR   = 4'b1110;
  localparam logic [3:0] FL_LU   = 4'b0100;
  localparam logic [3:0] FL_IM   = 4'b1000;

  logic [38:0] exp_q[$];
  string       name_q[$];
  int          n_run  = 0;
  int          n_fail = 0;
  logic [38:0] act;
  logic [38:0] exp_v;
  string       exp_n;

  assign act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush,
                pc_sel_branch, dmem_cancel, halted, err, state, stall_cnt,
                dut.wait_cnt};

  // expected vector: en, flush, {pc_sel_branch, dmem_cancel}, halted, err, state, stall_cnt, wait_cnt
  function automatic logic [38:0] mk(logic [4:0] en, logic [3:0] fl, logic [1:0] br,
                                     logic h, logic e, logic [1:0] st,
                                     logic [15:0] sc, logic [7:0] wc);
    return {en, fl, br, h, e, st, sc, wc};
  endfunction

  task automatic step(string n, logic r, logic [5:0] in, logic [38:0] e);
    @(posedge clk);
    #1;
    rst = r;
    {halt_wb, br_taken, dmem_req, dmem_done, id_load_use, imem_stall} = in;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // reset falls between edges; the expectation is sampled before the next edge
  task automatic step_arst(string n, logic [5:0] in, logic [38:0] e);
    @(posedge clk);
    #1;
    {halt_wb, br_taken, dmem_req, dmem_done, id_load_use, imem_stall} = in;
    #1;
    rst = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      exp_n = name_q.pop_front();
      n_run++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %b_%b_%b_%b%b_%0d_%0d_%0d expected %b_%b_%b_%b%b_%0d_%0d_%0d",
                 exp_n, act[38:34], act[33:30], act[29:28], act[27], act[26],
                 act[25:24], act[23:8], act[7:0],
                 exp_v[38:34], exp_v[33:30], exp_v[29:28], exp_v[27], exp_v[26],
                 exp_v[25:24], exp_v[23:8], exp_v[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // reset holds no-event outputs whatever the inputs
    step("rst_hold0", 1'b0, I_BUSY | I_LU, mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("rst_hold1", 1'b0, I_HALT,        mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("rst_rel",   1'b1, I_IDLE,        mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));

    // three busy cycles then completion
    step("dw_busy1", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("dw_busy2", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd1, 8'd1));
    step("dw_busy3", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd2, 8'd2));
    step("dw_done",  1'b1, I_DONE, mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd1, 16'd3, 8'd3));
    step("dw_after", 1'b1, I_IDLE, mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd0, 16'd3, 8'd0));

    // branch taken while waiting on data memory
    step("br_busy1", 1'b1, I_BUSY,        mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd0, 16'd3, 8'd0));
    step("br_busy2", 1'b1, I_BUSY,        mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd4, 8'd1));
    step("br_dwait", 1'b1, I_BR | I_BUSY, mk(EN_ALL,  FL_BR,   2'b11, 0, 0, 2'd1, 16'd5, 8'd2));
    step("br_after", 1'b1, I_IDLE,        mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd0, 16'd5, 8'd0));

    // load-use / fetch stall priorities
    step("lu_im",     1'b1, I_LU | I_IM,        mk(EN_LU,   FL_LU,   2'b00, 0, 0, 2'd0, 16'd5,  8'd0));
    step("im_only",   1'b1, I_IM,               mk(EN_IM,   FL_IM,   2'b00, 0, 0, 2'd0, 16'd6,  8'd0));
    step("lu_only",   1'b1, I_LU,               mk(EN_LU,   FL_LU,   2'b00, 0, 0, 2'd0, 16'd7,  8'd0));
    step("br_lu_im",  1'b1, I_BR | I_LU | I_IM, mk(EN_ALL,  FL_BR,   2'b11, 0, 0, 2'd0, 16'd8,  8'd0));
    step("busy_lu",   1'b1, I_BUSY | I_LU,      mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd0, 16'd8,  8'd0));
    step("done_lu",   1'b1, I_DONE | I_LU,      mk(EN_LU,   FL_LU,   2'b00, 0, 0, 2'd1, 16'd9,  8'd1));
    step("done_noreq",1'b1, 6'b000100,          mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd0, 16'd10, 8'd0));

    // halt wins over busy, then everything freezes
    step("halt_busy", 1'b1, I_HALT | I_BUSY, mk(EN_NONE, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd10, 8'd0));
    for (int i = 0; i < 100; i++)
      step("halt_frozen", 1'b1, 6'(i * 7), mk(EN_NONE, FL_NONE, 2'b00, 1, 0, 2'd2, 16'd11, 8'd0));
    step("halt_rst", 1'b0, I_IDLE, mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("halt_rel", 1'b1, I_IDLE, mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));

    // stall timeout with TIMEOUT = 4
    step("to_busy1", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("to_busy2", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd1, 8'd1));
    step("to_busy3", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd2, 8'd2));
    step("to_busy4", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd3, 8'd3));
    for (int i = 0; i < 6; i++)
      step("to_err", 1'b1, 6'(i * 11 + 3), mk(EN_NONE, FL_NONE, 2'b00, 0, 1, 2'd3, 16'd4, 8'd4));
    step("err_rst", 1'b0, I_IDLE, mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("err_rel", 1'b1, I_IDLE, mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));

    // asynchronous reset in the middle of a DWAIT cycle
    step("ar_busy1", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("ar_busy2", 1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd1, 16'd1, 8'd1));
    step_arst("ar_mid",    I_BUSY, mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("ar_rel",   1'b1, I_BUSY, mk(EN_BUSY, FL_BUSY, 2'b00, 0, 0, 2'd0, 16'd0, 8'd0));
    step("ar_done",  1'b1, I_DONE, mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd1, 16'd1, 8'd1));
    step("ar_idle",  1'b1, I_IDLE, mk(EN_ALL,  FL_NONE, 2'b00, 0, 0, 2'd0, 16'd1, 8'd0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, setting the data-memory stall limit in cycles (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have inputs id_load_use (1, decode load-use hazard), imem_stall (1, fetch not ready), dmem_req (1, EX/MEM holds a memory op), dmem_done (1, data memory completes this cycle).
REQ-005 SHALL have inputs br_taken (1, MEM/WB br_cond_out) and halt_wb (1, MEM/WB halt_out).
REQ-006 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, memwb_en (1 each): pipeline register load enables.
REQ-007 SHALL have outputs ifid_flush, idex_flush, exmem_flush, memwb_flush (1 each): the register loads a bubble (all zero) on this edge, overriding its enable.
REQ-008 SHALL have outputs pc_sel_branch (1, PC loads pc_branch), dmem_cancel (1, abort wrong-path access), halted (1), err (1), state (2), stall_cnt (16).

Function
REQ-009 SHALL implement states RUN=0, DWAIT=1, HALTED=2, ERR=3, with state driven directly from the state register.
REQ-010 SHALL define busy = dmem_req AND NOT dmem_done.
REQ-011 SHALL, in RUN/DWAIT, resolve same-cycle events with priority halt_wb > br_taken > busy > id_load_use > imem_stall.
REQ-012 SHALL, with no event, drive every en=1, every flush=0, pc_sel_branch=0, dmem_cancel=0.
REQ-013 SHALL, on halt_wb, drive every en=0 and every flush=0, then go to HALTED.
REQ-014 SHALL, on br_taken, drive every en=1, pc_sel_branch=1, ifid_flush=idex_flush=exmem_flush=1, dmem_cancel=1, then go to RUN; this applies from DWAIT as well.
REQ-015 SHALL, on busy, drive pc_en=ifid_en=idex_en=exmem_en=0 and memwb_flush=1, then go to DWAIT.
REQ-016 SHALL, on id_load_use, drive pc_en=ifid_en=0 and idex_flush=1, with all other registers advancing.
REQ-017 SHALL, on imem_stall, drive pc_en=0 and ifid_flush=1, with all other registers advancing.
REQ-018 SHALL, in DWAIT, leave for RUN in the cycle dmem_done=1, advancing normally in that same cycle (Mealy).
REQ-019 SHALL keep an 8-bit wait_cnt that increments each busy cycle and clears on any non-busy cycle or on br_taken.
REQ-020 SHALL go to ERR on the next edge when busy and wait_cnt = TIMEOUT-1 (the TIMEOUT-th consecutive busy cycle).
REQ-021 SHALL, in HALTED and ERR, drive every en=0, every flush=0, pc_sel_branch=0, and ignore all inputs until reset.
REQ-022 SHALL assert halted=1 only in HALTED and err=1 only in ERR.
REQ-023 SHALL increment stall_cnt in every RUN/DWAIT cycle with pc_en=0, saturating at 16'hFFFF with no wrap.

Reset
REQ-024 SHALL, while rst=0, force state=RUN, wait_cnt=0, stall_cnt=0, halted=0, err=0, and all combinational outputs to the no-event values of REQ-012.
REQ-025 SHALL return any state, including mid-DWAIT, to RUN asynchronously when rst falls.
REQ-026 SHALL begin normal operation on the first rising edge after rst rises.

Structure
REQ-027 SHALL take its state encodings and TIMEOUT default from a shared header, pipe_ctrl_defs, also used by the hazard unit and testbench.
REQ-028 SHALL instantiate a sub-module sat_cnt (parameterized width, enable, clear, saturating) for both wait_cnt and stall_cnt.
REQ-029 SHALL hold the state register in the existing dff primitives with reset routed asynchronously.

Verification
REQ-030 SHALL cover: dmem_req=1 with dmem_done=0 for 3 cycles, then 1 -> pc_en=0 for 3 cycles, memwb_flush=1 for 3 cycles, state=DWAIT, all en=1 in cycle 4, stall_cnt=3.
REQ-031 SHALL cover: br_taken=1 during DWAIT -> pc_sel_branch=1, three flushes=1, dmem_cancel=1, state=RUN next edge, wait_cnt=0.
REQ-032 SHALL cover: id_load_use=1 and imem_stall=1 together -> ifid_en=0, idex_flush=1, ifid_flush=0.
REQ-033 SHALL cover: halt_wb=1 with busy=1 -> all en=0, halted=1 next cycle, outputs frozen for 100 cycles.
REQ-034 SHALL cover: TIMEOUT=4 with busy held -> err=1 after the 4th busy cycle, state=3.
REQ-035 SHALL cover: rst=0 mid-DWAIT between clock edges -> state=0 immediately, stall_cnt=0.
